// File: rtl/instruction_issue_unit.sv
// Buffered instruction issuer: queues host instructions, issues one per cycle onto
// the MasterController bus, and returns each READ_OP result with its instruction.
module instruction_issue_unit #(
  parameter int unsigned depth   = 3,
  parameter int unsigned W       = 16,
  parameter int unsigned QA      = 4,
  parameter int unsigned RL      = 1,
  parameter logic [3:0]  READ_OP = 4'b0011,
  localparam int unsigned D        = 1 << depth,
  localparam int unsigned insW     = (depth > 2) ? depth : 2,
  localparam int unsigned insD     = (D > W) ? D : W,
  localparam int unsigned insWidth = 4 + 2 + 2 * insW + insD
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  flush,
  input  logic [insWidth-1:0]   insIn,
  input  logic                  insInValid,
  output logic                  insInReady,
  input  logic                  stall,
  output logic [insWidth-1:0]   instruction,
  output logic                  insIssued,
  input  logic [W-1:0]          dataOut,
  output logic [insWidth+W-1:0] resData,
  output logic                  resValid,
  input  logic                  resReady,
  output logic [QA:0]           count
);

  localparam int unsigned QD   = 1 << QA;
  localparam logic [QA:0] FULL = (QA + 1)'(QD);

  logic [insWidth-1:0] mem [QD];
  logic [QA:0]         wrPtr, rdPtr;
  logic [insWidth-1:0] head;
  logic                headIsRead, readBusy, push, pop;

  // Stage 0 lines up with the read on the bus; stage RL lines up with its dataOut.
  logic [RL:0]         pipeVld;
  logic [insWidth-1:0] pipeIns [RL+1];

  always_comb begin
    count      = wrPtr - rdPtr;
    insInReady = (count != FULL);
    head       = mem[rdPtr[QA-1:0]];
    headIsRead = (head[insWidth-1 -: 4] == READ_OP);
    readBusy   = (|pipeVld) || resValid;
    push       = insInValid && insInReady && !flush;
    pop        = (count != '0) && !stall && !flush && !(headIsRead && readBusy);
  end

  always_ff @(posedge CLK) begin
    if (push && RST_N) mem[wrPtr[QA-1:0]] <= insIn;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      instruction <= '0;
      insIssued   <= 1'b0;
      pipeVld     <= '0;
      resValid    <= 1'b0;
      resData     <= '0;
      for (int unsigned i = 0; i <= RL; i++) pipeIns[i] <= '0;
    end else if (flush) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      instruction <= '0;
      insIssued   <= 1'b0;
      pipeVld     <= '0;
      for (int unsigned i = 0; i <= RL; i++) pipeIns[i] <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      instruction <= pop ? head : '0;
      insIssued   <= pop;
      pipeVld[0]  <= pop && headIsRead;
      pipeIns[0]  <= head;
      for (int unsigned i = RL; i > 0; i--) begin
        pipeVld[i] <= pipeVld[i-1];
        pipeIns[i] <= pipeIns[i-1];
      end
      // Drain and capture never coincide: a read only issues with the slot empty.
      if (resValid && resReady) resValid <= 1'b0;
      if (pipeVld[RL]) begin
        resValid <= 1'b1;
        resData  <= {pipeIns[RL], dataOut};
      end
    end
  end

endmodule

// File: doc/instruction_issue_unit.md
# instruction_issue_unit

Buffered instruction issuer that replaces file-driven instruction feeding with synthesizable hardware. It sits between the host/DMA side and `MasterController`. It queues host instructions in a parametrised FIFO and issues at most one per cycle onto the controller's `instruction` bus, honouring a stall input. For every read-type instruction it captures the controller's `dataOut` a fixed latency later and returns it to the host as `{instruction, dataOut}` over a valid/ready channel.

## Interface
- `depth`, 3, log2 of PE array dimension; `D = 1<<depth`
- `W`, 16, data word width
- `insW`, derived: max(2, depth)
- `insD`, derived: max(D, W)
- `insWidth`, derived: 4 + 2 + 2*insW + insD (28 at defaults); opcode is bits [insWidth-1 -: 4]
- `QA`, 4, log2 of FIFO entries (`QD = 1<<QA`, 16 entries)
- `RL`, 1, read latency in cycles from issue to valid `dataOut`, legal 0..3
- `READ_OP`, 4'b0011, opcode whose result is captured
- `CLK`  in  1  single clock, all logic on posedge
- `RST_N`  in  1  synchronous active-low reset
- `flush`  in  1  synchronous; empties FIFO and in-flight read tracking
- `insIn`  in  insWidth  host instruction
- `insInValid`  in  1  host offers `insIn`
- `insInReady`  out  1  FIFO not full
- `stall`  in  1  controller cannot accept a new instruction this cycle
- `instruction`  out  insWidth  registered issue bus to `MasterController`; all-zero = NOP
- `insIssued`  out  1  `instruction` holds a real (popped) instruction this cycle
- `dataOut`  in  W  controller data output
- `resData`  out  insWidth+W  {issued read instruction, captured dataOut}
- `resValid`  out  1  result slot full
- `resReady`  in  1  host consumes result
- `count`  out  QA+1  FIFO occupancy 0..QD

## Operation
- FIFO: circular buffer, read/write pointers QA+1 bits (wrap bit distinguishes full/empty). Push when `insInValid && insInReady`. `insInReady = (count != QD)`. A push and a pop in the same cycle are both performed and `count` is unchanged. A full FIFO does not accept a push in the same cycle as a pop (no bypass).
- Pop/issue condition at a posedge: FIFO non-empty, `!stall`, `!flush`, and, if head opcode == READ_OP, `readBusy == 0`. `readBusy` = read in flight OR `resValid`.
- On issue: `instruction <= head`, `insIssued <= 1`. Otherwise `instruction <= 0`, `insIssued <= 0`. No instruction is ever held on the bus for more than one cycle.
- Read tracking: on issuing READ_OP, load an RL-stage shift register with the instruction and a valid bit. The stage aligned with `dataOut` RL cycles after the issue cycle writes `resData <= {ins, dataOut}` and sets `resValid`. For RL = 0, capture happens at the posedge ending the cycle in which `instruction` shows the read.
- Result slot: single entry. It clears on `resValid && resReady`. It cannot be overwritten because a read issues only when the slot and pipeline are empty. A read is therefore blocked in the cycle the slot drains; it issues at the next posedge at the earliest.
- Non-read instructions never wait on the result path. A blocked read at the head stalls everything behind it (in-order).
- `flush`: pointers to 0, `count` 0, read pipeline cleared, `instruction`/`insIssued` to 0. `resValid`/`resData` keep their value. A push in the flush cycle is dropped.
- Reset (`!RST_N` at posedge): `instruction=0`, `insIssued=0`, `insInReady=1`, `count=0`, `resValid=0`, `resData=0`, pointers and read pipeline 0. Reset overrides flush and all handshakes, including mid-read.

## Timing
- Push at edge t → `count` reflects it after t. The earliest issue is edge t+1, and `instruction` is valid during cycle t+1..t+2.
- Issue throughput: 1 instruction/cycle while unstalled and non-read.
- Read-to-read minimum spacing: RL+1 cycles of pipeline, plus at least 1 cycle of slot occupancy.
- `stall` is sampled at the issuing edge. A stall asserted in cycle c prevents the issue at the end of c; the instruction already on the bus is not retracted.
- `insInReady`, `resValid`, `count` are registered-state derived; no combinational path from `insInValid`/`resReady` to them.

## Test plan
- Reset/idle: hold RST_N=0 3 cycles with insInValid=1 → count=0, instruction=0, insIssued=0, resValid=0, insInReady=1.
- Streaming: push 5 non-read instructions (opcode 0001, payload 1..5) back-to-back, stall=0 → they appear on `instruction` in order on consecutive cycles starting 1 cycle after first push; count never exceeds 1.
- Full/back-pressure: stall=1, push 17 → insInReady drops after 16th, count=16, 17th not accepted; release stall → 16 issued in order, count returns to 0.
- Read capture (RL=1): issue READ_OP with payload 0xABCD, drive dataOut=0x1234 in cycle after issue → resValid=1, resData={ins,16'h1234}; second queued read waits until resReady pulse, issues next edge after drain.
- Stall/flush mix: queue 4, assert stall 2 cycles mid-stream, then flush with a read in flight → no issue during stall, after flush count=0, no result captured, prior resValid unchanged.
- Simultaneous push/pop at count=8 → count stays 8, issue order preserved across pointer wrap past entry 15.
